mmio_write_dispatch: RTL and testbench
======================================

# mmio_write_dispatch

Parametrised store-address decoder and buffered write dispatcher between the MEM stage and the memory-mapped peripherals. It routes each store either to DMEM or to one of NUM_CH peripheral channels in the 0x800 window. Each peripheral channel holds its write in a one-entry valid/ready buffer, and the block asserts a stall to the pipeline when the target buffer cannot accept. It supersedes the fixed single-peripheral write select.

## Interface
Parameters:
- NUM_CH, 6, number of peripheral channels (1..32)
- BASE_ADDR, 12'h800, addr[11:0] of channel 0
- DATA_W, 32, store data width

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- addr  in  32  store address from MEM stage
- wdata  in  DATA_W  store data
- we  in  1  store request from MEM stage
- dmem_we  out  1  DMEM write enable, combinational
- stall  out  1  store cannot be accepted this cycle, combinational
- ch_valid  out  NUM_CH  per-channel buffered write pending
- ch_data  out  NUM_CH*DATA_W  per-channel buffered data, channel i at [i*DATA_W +: DATA_W]
- ch_ready  in  NUM_CH  per-channel peripheral accepts buffered write
- busy  out  1  OR of ch_valid, used by the pipeline for fence and drain
- err_clr  in  1  clears error state (WSEL_ERRCNT_EN only)
- err_cnt  out  16  unmapped-write count (WSEL_ERRCNT_EN only)
- err_irq  out  1  sticky unmapped-write flag (WSEL_ERRCNT_EN only)

## Operation
- Region decode:
  - addr[11]==0 is the DMEM region: dmem_we = we, and no channel is touched.
  - addr[11]==1 is the peripheral region: dmem_we = 0.
- Offset = addr[11:0] - BASE_ADDR. Channel index i = offset[7:2].
- Hit condition: addr[11]==1, offset[1:0]==0, offset < NUM_CH*4. Otherwise the store is unmapped.
- Unmapped peripheral store: silently dropped, no stall, error logic updated when enabled.
- Channel i buffer, one entry (ch_valid[i], data register):
  - transfer = ch_valid[i] & ch_ready[i]
  - accept = we & hit on i & (!ch_valid[i] | ch_ready[i])
  - On accept, the data register loads wdata and ch_valid[i] is 1 next cycle. This holds even when a transfer completes the same cycle (back-to-back, no bubble).
  - On transfer without accept, ch_valid[i] clears.
- stall = we & hit on i & ch_valid[i] & !ch_ready[i].
  - The pipeline holds addr, wdata and we stable while stall is high.
  - The block never drops a hitting store.
- ch_data[i] is stable while ch_valid[i] is high. The peripheral samples it on the transfer cycle.
- Only one store arrives per cycle, so at most one channel accepts per cycle. Transfers on all channels proceed independently and in parallel.
- Reset: ch_valid all 0, ch_data all 0, busy 0, err_cnt 0, err_irq 0. dmem_we and stall follow their inputs combinationally.
- Reset asserted mid-handshake discards the pending entry. The peripheral sees ch_valid fall with no transfer.

## Timing
- Decode, dmem_we and stall are combinational, in the same cycle as we.
- Store-to-ch_valid latency is 1 cycle.
- Sustained throughput is 1 write per cycle per channel while ch_ready stays high.
- Channel full with ch_ready low:
  - A store to that channel stalls every cycle until ch_ready rises.
  - It is accepted on the cycle ch_ready is high.
- A store to a different channel is never stalled by a full channel.

## Configuration
- WSEL_ERRCNT_EN defined:
  - Each unmapped accepted store increments err_cnt, saturating at 16'hFFFF. Unmapped means addr[11]==1 with a miss or a misaligned address.
  - err_irq is set on the first such store and stays set.
  - err_clr zeroes both next cycle. If err_clr and an unmapped store occur in the same cycle, err_clr wins.
- WSEL_ERRCNT_EN undefined:
  - err_cnt is tied to 0 and err_irq to 0, and err_clr is ignored.
  - No counter flops are synthesised.

## Test plan
- Store addr 0x0000_0100, we=1 -> dmem_we=1, stall=0, ch_valid stays 0.
- Store 0x0000_0804, data 0xDEADBEEF, ch_ready[1]=0 -> next cycle ch_valid[1]=1, ch_data[1]=0xDEADBEEF. A second store to 0x804 -> stall=1 until ch_ready[1]=1, then accepted and the new data visible next cycle.
- ch_ready all 1, stores to 0x800, 0x804, 0x814 on consecutive cycles -> each ch_valid pulses for 1 cycle, stall never asserts, busy drops 1 cycle after the last store.
- Store to 0x81C (channel 7, outside NUM_CH=6) and to 0x806 (misaligned) -> no ch_valid, stall=0, dmem_we=0. With WSEL_ERRCNT_EN, err_cnt=2 and err_irq=1. err_clr -> both 0.
- Channel 0 full and stalled while a store to channel 2 arrives -> channel 2 accepted with no stall, channel 0 entry unchanged.
- ch_valid[3]=1 with ch_ready low, assert rst for 1 cycle -> ch_valid=0, busy=0, err_cnt=0 immediately.

Source files
------------

// File: rtl/mmio_write_dispatch.sv
// Store-address decoder and buffered write dispatcher: routes MEM-stage stores to DMEM or to
// one of NUM_CH one-entry peripheral buffers. Optional unmapped-write counter: WSEL_ERRCNT_EN.
module mmio_write_dispatch #(
  parameter int          NUM_CH    = 6,
  parameter logic [11:0] BASE_ADDR = 12'h800,
  parameter int          DATA_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     we,
  output logic                     dmem_we,
  output logic                     stall,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_ready,
  output logic                     busy,
  input  logic                     err_clr,
  output logic [15:0]              err_cnt,
  output logic                     err_irq
);

  localparam logic [12:0] CH_SPAN = 13'(NUM_CH * 4);

  logic [11:0]       offset;
  logic [5:0]        ch_idx;
  logic              periph;
  logic              hit;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] transfer;

  // Handshake: a channel entry moves to the peripheral on any cycle where ch_valid[i] and
  // ch_ready[i] are both high; ch_data[i] holds steady while ch_valid[i] is high. A new store
  // may refill the entry in the very cycle it drains, so a ready peripheral sees no bubble.
  always_comb begin
    offset   = addr[11:0] - BASE_ADDR;
    ch_idx   = offset[7:2];
    periph   = addr[11];
    hit      = periph && (offset[1:0] == 2'b00) && ({1'b0, offset} < CH_SPAN);
    sel      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i] = hit && (ch_idx == 6'(i));
    end
    transfer = ch_valid & ch_ready;
    accept   = we ? (sel & (~ch_valid | ch_ready)) : '0;
    stall    = we && (|(sel & ch_valid & ~ch_ready));
    dmem_we  = we && !periph;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_valid <= '0;
      ch_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept[i]) begin
          ch_valid[i]                  <= 1'b1;
          ch_data[i*DATA_W +: DATA_W]  <= wdata;
        end else if (transfer[i]) begin
          ch_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign busy = |ch_valid;

`ifdef WSEL_ERRCNT_EN
  logic unmapped;
  assign unmapped = we && periph && !hit;

  // err_clr has priority over a same-cycle unmapped store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      err_irq <= 1'b0;
    end else if (err_clr) begin
      err_cnt <= '0;
      err_irq <= 1'b0;
    end else if (unmapped) begin
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      err_irq <= 1'b1;
    end
  end
`else
  assign err_cnt = '0;
  assign err_irq = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{addr[31:12], err_clr};

endmodule

// File: tb/tb_mmio_write_dispatch.sv
// Self-checking bench for mmio_write_dispatch: directed scenarios plus a negedge monitor with a
// reference model and an expected-write scoreboard. Honours WSEL_ERRCNT_EN when defined.
module tb_mmio_write_dispatch;

  localparam int NUM_CH = 6;
  localparam int DATA_W = 32;

  logic                     clk;
  logic                     rst;
  logic [31:0]              addr;
  logic [DATA_W-1:0]        wdata;
  logic                     we;
  logic                     dmem_we;
  logic                     stall;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_ready;
  logic                     busy;
  logic                     err_clr;
  logic [15:0]              err_cnt;
  logic                     err_irq;

  int n_tests = 0;
  int n_fail  = 0;

  mmio_write_dispatch #(.NUM_CH(NUM_CH), .BASE_ADDR(12'h800), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we),
    .dmem_we(dmem_we), .stall(stall), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .busy(busy), .err_clr(err_clr), .err_cnt(err_cnt), .err_irq(err_irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: {channel, data} pushed on accept, popped on transfer
  logic [39:0]       exp_q[$];
  logic [NUM_CH-1:0] mdl_v;
  logic [15:0]       mdl_cnt;
  logic              mdl_irq;
  logic              t_hit;
  int                t_ch;
  logic              exp_stall;
  int                found;

  always @(negedge clk) begin
    if (rst) begin
      mdl_v   = '0;
      mdl_cnt = '0;
      mdl_irq = 1'b0;
      exp_q.delete();
    end else begin
      t_hit = 1'b0;
      t_ch  = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (addr[11:0] == 12'h800 + 12'(4 * c)) begin
          t_hit = 1'b1;
          t_ch  = c;
        end
      end
      exp_stall = we && t_hit && mdl_v[t_ch] && !ch_ready[t_ch];
      n_tests++;
      if (stall !== exp_stall) begin
        n_fail++; $display("FAIL mon_stall: got %b expected %b addr %h", stall, exp_stall, addr);
      end
      n_tests++;
      if (dmem_we !== (we && !addr[11])) begin
        n_fail++; $display("FAIL mon_dmem_we: got %b addr %h we %b", dmem_we, addr, we);
      end
      n_tests++;
      if (ch_valid !== mdl_v) begin
        n_fail++; $display("FAIL mon_ch_valid: got %b expected %b", ch_valid, mdl_v);
      end
      n_tests++;
      if (err_cnt !== mdl_cnt || err_irq !== mdl_irq) begin
        n_fail++; $display("FAIL mon_err: got cnt %h irq %b expected cnt %h irq %b",
                           err_cnt, err_irq, mdl_cnt, mdl_irq);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (mdl_v[c] && ch_ready[c]) begin
          found = -1;
          for (int k = 0; k < exp_q.size(); k++) begin
            if (exp_q[k][39:32] == 8'(c)) begin
              found = k;
              break;
            end
          end
          n_tests++;
          if (found < 0) begin
            n_fail++; $display("FAIL sb_transfer: channel %0d transfer with no expected entry", c);
          end else begin
            if (ch_data[c*DATA_W +: DATA_W] !== exp_q[found][31:0]) begin
              n_fail++; $display("FAIL sb_data: ch %0d got %h expected %h",
                                 c, ch_data[c*DATA_W +: DATA_W], exp_q[found][31:0]);
            end
            exp_q.delete(found);
          end
          mdl_v[c] = 1'b0;
        end
      end
      if (we && t_hit && !exp_stall) begin
        exp_q.push_back({8'(t_ch), wdata});
        mdl_v[t_ch] = 1'b1;
      end
`ifdef WSEL_ERRCNT_EN
      if (err_clr) begin
        mdl_cnt = '0;
        mdl_irq = 1'b0;
      end else if (we && addr[11] && !t_hit) begin
        if (mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
        mdl_irq = 1'b1;
      end
`endif
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    int n;
    we = 1'b1; addr = a; wdata = d; n = 0;
    #1;
    while (stall && n < 50) begin
      tick();
      ch_ready = NUM_CH'($urandom);
      #1;
      n++;
    end
    n_tests++;
    if (n >= 50) begin
      n_fail++; $display("FAIL store_timeout: stall still %b after %0d cycles, expected 0", stall, n);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b1; addr = 32'h0000_0100; wdata = '0; ch_ready = '0; err_clr = 1'b0;
    tick();
    n_tests++;
    if (ch_valid !== '0 || busy !== 1'b0 || ch_data !== '0) begin
      n_fail++; $display("FAIL reset_regs: got valid %b busy %b, expected 0 0", ch_valid, busy);
    end
    n_tests++;
    if (err_cnt !== 16'h0 || err_irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got cnt %h irq %b expected 0 0", err_cnt, err_irq);
    end
    n_tests++;
    if (dmem_we !== 1'b1) begin
      n_fail++; $display("FAIL reset_dmem_we: got %b expected 1", dmem_we);
    end
    we = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_dmem();
    we = 1'b1; addr = 32'h0000_0100; wdata = 32'h1234_5678;
    #1;
    n_tests++;
    if (dmem_we !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL dmem_decode: got dmem_we %b stall %b expected 1 0", dmem_we, stall);
    end
    tick();
    we = 1'b0;
    n_tests++;
    if (ch_valid !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL dmem_no_ch: got valid %b busy %b expected 0 0", ch_valid, busy);
    end
  endtask

  task automatic test_stall();
    ch_ready = '0; we = 1'b1; addr = 32'h0000_0804; wdata = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL stall_first: got %b expected 0", stall);
    end
    tick();
    we = 1'b0;
    n_tests++;
    if (ch_valid[1] !== 1'b1 || ch_data[63:32] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL stall_load: got valid %b data %h expected 1 deadbeef",
                         ch_valid[1], ch_data[63:32]);
    end
    we = 1'b1; wdata = 32'hCAFE_F00D;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (stall !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold: cycle %0d got %b expected 1", i, stall);
      end
      tick();
    end
    ch_ready[1] = 1'b1;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: got %b expected 0", stall);
    end
    tick();
    we = 1'b0;
    n_tests++;
    if (ch_valid[1] !== 1'b1 || ch_data[63:32] !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL stall_reload: got valid %b data %h expected 1 cafef00d",
                         ch_valid[1], ch_data[63:32]);
    end
    tick();
    n_tests++;
    if (ch_valid[1] !== 1'b0) begin
      n_fail++; $display("FAIL stall_drain: got %b expected 0", ch_valid[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_tab [3];
    logic [5:0]  v_tab [3];
    a_tab[0] = 32'h800; a_tab[1] = 32'h804; a_tab[2] = 32'h814;
    v_tab[0] = 6'b000001; v_tab[1] = 6'b000010; v_tab[2] = 6'b100000;
    ch_ready = '1;
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; addr = a_tab[i]; wdata = 32'hA000_0000 + 32'(i);
      #1;
      n_tests++;
      if (stall !== 1'b0) begin
        n_fail++; $display("FAIL b2b_stall: store %0d got %b expected 0", i, stall);
      end
      tick();
      n_tests++;
      if (ch_valid !== v_tab[i]) begin
        n_fail++; $display("FAIL b2b_valid: store %0d got %b expected %b", i, ch_valid, v_tab[i]);
      end
    end
    we = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_busy_hi: got %b expected 1", busy);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || ch_valid !== '0) begin
      n_fail++; $display("FAIL b2b_busy_lo: got busy %b valid %b expected 0 0", busy, ch_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = {21'h0, 11'($urandom)};
      else if (kind == 1) a = 32'h800 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(1, 3));
      else if (kind == 2) a = 32'h800 + 32'($urandom_range(6, 40) * 4);
      else                a = 32'h800 + 32'($urandom_range(0, NUM_CH - 1) * 4);
      ch_ready = NUM_CH'($urandom);
      do_store(a, $urandom);
    end
    we = 1'b0; ch_ready = '1;
    tick();
    tick();
  endtask

  task automatic test_unmapped();
    logic [15:0] exp_cnt;
    logic        exp_irq;
`ifdef WSEL_ERRCNT_EN
    exp_cnt = 16'd2; exp_irq = 1'b1;
`else
    exp_cnt = 16'd0; exp_irq = 1'b0;
`endif
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    we = 1'b1; addr = 32'h81C; wdata = 32'h1111_1111;
    #1;
    n_tests++;
    if (stall !== 1'b0 || dmem_we !== 1'b0) begin
      n_fail++; $display("FAIL unmap_range: got stall %b dmem_we %b expected 0 0", stall, dmem_we);
    end
    tick();
    addr = 32'h806;
    #1;
    n_tests++;
    if (stall !== 1'b0 || dmem_we !== 1'b0) begin
      n_fail++; $display("FAIL unmap_align: got stall %b dmem_we %b expected 0 0", stall, dmem_we);
    end
    tick();
    we = 1'b0;
    n_tests++;
    if (ch_valid !== '0 || err_cnt !== exp_cnt || err_irq !== exp_irq) begin
      n_fail++; $display("FAIL unmap_err: got valid %b cnt %h irq %b expected 0 %h %b",
                         ch_valid, err_cnt, err_irq, exp_cnt, exp_irq);
    end
    err_clr = 1'b1; we = 1'b1; addr = 32'h81C;
    tick();
    err_clr = 1'b0; we = 1'b0;
    n_tests++;
    if (err_cnt !== 16'h0 || err_irq !== 1'b0) begin
      n_fail++; $display("FAIL unmap_clr: got cnt %h irq %b expected 0 0", err_cnt, err_irq);
    end
  endtask

  task automatic test_independent();
    ch_ready = '0; we = 1'b1; addr = 32'h800; wdata = 32'hAAAA_0000;
    tick();
    addr = 32'h808; wdata = 32'hBBBB_2222;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL indep_stall: got %b expected 0", stall);
    end
    tick();
    we = 1'b0;
    n_tests++;
    if (ch_valid[2] !== 1'b1 || ch_valid[0] !== 1'b1 || ch_data[31:0] !== 32'hAAAA_0000) begin
      n_fail++; $display("FAIL indep_state: got valid %b ch0 %h expected ch0,ch2 set aaaa0000",
                         ch_valid, ch_data[31:0]);
    end
    ch_ready = '1;
    tick();
    tick();
    n_tests++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got %0d entries busy %b expected 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    ch_ready = '0; we = 1'b1; addr = 32'h81C; wdata = '0;
    tick();
    addr = 32'h80C; wdata = 32'h3333_3333;
    tick();
    we = 1'b0;
    n_tests++;
    if (ch_valid[3] !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pending: got %b expected 1", ch_valid[3]);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (ch_valid !== '0 || busy !== 1'b0 || err_cnt !== 16'h0 || err_irq !== 1'b0) begin
      n_fail++; $display("FAIL rmid_clear: got valid %b busy %b cnt %h irq %b expected all 0",
                         ch_valid, busy, err_cnt, err_irq);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_dmem();
    test_stall();
    test_back_to_back();
    test_random();
    test_unmapped();
    test_independent();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
